// File: rtl/vlsu_pkg.sv
// vlsu_pkg: shared FSM state, op-kind enums and op decode for mem_vector_lsu.
package vlsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD, S_DONE} state_t;
  typedef enum logic [2:0] {OP_NOP, OP_LD_S, OP_LD_V, OP_ST_S, OP_ST_V} op_t;
  function automatic op_t vlsu_decode(input logic we, input logic ld, input logic vec);
    return we ? (vec ? OP_ST_V : OP_ST_S) : ld ? (vec ? OP_LD_V : OP_LD_S) : OP_NOP;
  endfunction
endpackage

// File: rtl/vlsu_addr_gen.sv
// vlsu_addr_gen: element counter with clear/advance and last flag, plus base + idx address adder.
module vlsu_addr_gen #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [IW-1:0] lim_i,
  input  logic [N-1:0]  base_i,
  output logic [IW-1:0] idx_o,
  output logic          last_o,
  output logic [N-1:0]  addr_o
);
  logic [IW-1:0] idx_q, idx_d;
  assign idx_d  = clr_i ? '0 : adv_i ? idx_q + 1'b1 : idx_q;
  assign idx_o  = idx_q;
  assign last_o = idx_q == lim_i;
  assign addr_o = base_i + N'(idx_q);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) idx_q <= '0;
    else idx_q <= idx_d;
endmodule

// File: rtl/mem_vector_lsu.sv
// mem_vector_lsu: MEM-stage scalar/vector load/store unit over a single-word memory port.
// Optional bounds check enabled by defining VLSU_BOUNDS_CHECK_EN.
module mem_vector_lsu
  import vlsu_pkg::*;
#(
  parameter int N         = 32,
  parameter int V         = 20,
  parameter int MEM_DEPTH = 256
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                valid_i,
  input  logic                MemWE_i,
  input  logic                WBSelect_i,
  input  logic                OpSource_i,
  input  logic [N-1:0]        Addr_i,
  input  logic [N-1:0]        StoreData_S_i,
  input  logic [V-1:0][N-1:0] StoreData_V_i,
  output logic [N-1:0]        mem_addr_o,
  output logic                mem_we_o,
  output logic [N-1:0]        mem_wdata_o,
  input  logic [N-1:0]        mem_rdata_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [N-1:0]        LoadData_S_o,
  output logic [V-1:0][N-1:0] LoadData_V_o
`ifdef VLSU_BOUNDS_CHECK_EN
  ,
  output logic                addr_err_o
`endif
);
  localparam int IW = $clog2(V + 1);
  localparam int AW = N + 1;
  state_t state_q, state_d;
  op_t op;
  logic [IW-1:0] idx, lim;
  logic [N-1:0] addr, ld_s_q;
  logic [V-1:0][N-1:0] ld_v_q;
  logic vec, idle, in_st, in_ld, in_dn, last, err, go, st_s, st_v0, ld0, wr, clr, adv;
  assign vec   = OpSource_i;
  assign op    = valid_i ? vlsu_decode(MemWE_i, WBSelect_i, vec) : OP_NOP;
  assign idle  = state_q == S_IDLE;
  assign in_st = state_q == S_STORE;
  assign in_ld = state_q == S_LOAD;
  assign in_dn = state_q == S_DONE;
`ifdef VLSU_BOUNDS_CHECK_EN
  assign err = idle && op != OP_NOP && ({1'b0, Addr_i} + AW'(vec ? V - 1 : 0)) >= AW'(MEM_DEPTH);
  assign addr_err_o = RST & err;
`else
  assign err = 1'b0;
`endif
  assign go    = idle & ~err;
  assign st_s  = go & (op == OP_ST_S);
  assign st_v0 = go & (op == OP_ST_V);
  assign ld0   = go & (op == OP_LD_S || op == OP_LD_V);
  assign wr    = st_s | st_v0 | in_st;
  // Loads count one extra step past the last address to capture the trailing read.
  assign lim   = in_ld ? (vec ? IW'(V) : IW'(1)) : IW'(V - 1);
  assign clr   = in_dn | ((in_st | in_ld) & last);
  assign adv   = st_v0 | ld0 | ((in_st | in_ld) & ~last);
  always_comb
    state_d = in_dn ? S_IDLE : in_st ? (last ? S_IDLE : S_STORE) :
              in_ld ? (last ? S_DONE : S_LOAD) : st_v0 ? S_STORE : ld0 ? S_LOAD : S_IDLE;
  vlsu_addr_gen #(.N(N), .IW(IW)) u_addr_gen (
    .CLK(CLK), .RST(RST), .clr_i(clr), .adv_i(adv), .lim_i(lim),
    .base_i(Addr_i), .idx_o(idx), .last_o(last), .addr_o(addr)
  );
  assign mem_we_o     = RST & wr;
  assign mem_addr_o   = RST ? addr : '0;
  assign mem_wdata_o  = (RST & wr) ? (vec ? StoreData_V_i[idx] : StoreData_S_i) : '0;
  assign stall_o      = RST & (st_v0 | ld0 | in_ld | (in_st & ~last));
  assign done_o       = RST & (st_s | err | in_dn | (in_st & last));
  assign LoadData_S_o = ld_s_q;
  assign LoadData_V_o = ld_v_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= S_IDLE;
      ld_s_q  <= '0;
      ld_v_q  <= '0;
    end else begin
      state_q <= state_d;
      if (in_ld && !vec) ld_s_q <= mem_rdata_i;
      for (int k = 0; k < V; k++)
        if (in_ld && vec && idx == IW'(k + 1)) ld_v_q[k] <= mem_rdata_i;
    end
endmodule

// File: tb/tb_mem_vector_lsu.sv
// tb_mem_vector_lsu: scoreboard bench for mem_vector_lsu; memory reads return addr*2.
module tb_mem_vector_lsu;
  localparam int N = 32;
  localparam int V = 20;
  logic CLK = 1'b0;
  logic RST, valid_i, MemWE_i, WBSelect_i, OpSource_i;
  logic [N-1:0] Addr_i, StoreData_S_i, mem_addr_o, mem_wdata_o, mem_rdata_i, LoadData_S_o;
  logic [V-1:0][N-1:0] StoreData_V_i, LoadData_V_o;
  logic mem_we_o, stall_o, done_o, last_err;
`ifdef VLSU_BOUNDS_CHECK_EN
  logic addr_err_o;
`endif
  int n_chk = 0, n_fail = 0;
  logic [63:0] wq[$];

  mem_vector_lsu #(.N(N), .V(V), .MEM_DEPTH(256)) dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i),
    .OpSource_i(OpSource_i), .Addr_i(Addr_i), .StoreData_S_i(StoreData_S_i),
    .StoreData_V_i(StoreData_V_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .done_o(done_o),
    .LoadData_S_o(LoadData_S_o), .LoadData_V_o(LoadData_V_o)
`ifdef VLSU_BOUNDS_CHECK_EN
    , .addr_err_o(addr_err_o)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) mem_rdata_i <= mem_addr_o * 2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK)
    if (mem_we_o === 1'b1) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected got=%0h exp=none", {mem_addr_o, mem_wdata_o});
      end else chk("wr", {mem_addr_o, mem_wdata_o}, wq.pop_front());
    end

  task automatic push_vec(input logic [N-1:0] a, input int cnt);
    for (int i = 0; i < cnt; i++) wq.push_back({a + N'(i), StoreData_V_i[i]});
  endtask

  task automatic run_op(input string tag, input logic we, input logic ld, input logic src,
                        input logic [N-1:0] a, input int exp_cyc);
    int cyc = 0;
    int stalls = 0;
    valid_i = 1'b1; MemWE_i = we; WBSelect_i = ld; OpSource_i = src; Addr_i = a;
    do begin
      @(negedge CLK);
      if (stall_o) stalls++;
      cyc++;
    end while (!done_o && cyc < 100);
    chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_cyc - 1));
`ifdef VLSU_BOUNDS_CHECK_EN
    last_err = addr_err_o;
`else
    last_err = 1'b0;
`endif
  endtask

  task automatic fin(input string tag);
    @(posedge CLK);
    #1;
    valid_i = 1'b0; MemWE_i = 1'b0; WBSelect_i = 1'b0;
    chk({tag, "_wq_empty"}, 64'(wq.size()), 64'd0);
  endtask

  initial begin
    RST = 1'b0; valid_i = 1'b1; MemWE_i = 1'b1; WBSelect_i = 1'b0; OpSource_i = 1'b0;
    Addr_i = 5; StoreData_S_i = 'hA5;
    for (int i = 0; i < V; i++) StoreData_V_i[i] = N'(i + 1);
    @(negedge CLK);
    chk("rst_we", 64'(mem_we_o), 0);
    chk("rst_addr", 64'(mem_addr_o), 0);
    chk("rst_wdata", 64'(mem_wdata_o), 0);
    chk("rst_stall", 64'(stall_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_lds", 64'(LoadData_S_o), 0);
    chk("rst_ldv", 64'(|LoadData_V_o), 0);
`ifdef VLSU_BOUNDS_CHECK_EN
    chk("rst_err", 64'(addr_err_o), 0);
`endif
    @(posedge CLK);
    #1;
    RST = 1'b1; valid_i = 1'b0; MemWE_i = 1'b0;

    wq.push_back({32'd5, 32'hA5});
    run_op("st_s", 1, 0, 0, 5, 1);
    fin("st_s");
    push_vec(16, V);
    run_op("st_v", 1, 0, 1, 16, V);
    fin("st_v");
    run_op("ld_v", 0, 1, 1, 0, V + 2);
    for (int i = 0; i < V; i++) chk("ld_v_el", 64'(LoadData_V_o[i]), 64'(2 * i));
    fin("ld_v");
    run_op("ld_s", 0, 1, 0, 7, 3);
    chk("ld_s_val", 64'(LoadData_S_o), 14);
    chk("ld_v_hold", 64'(LoadData_V_o[3]), 6);
    fin("ld_s");

    valid_i = 1'b1; OpSource_i = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("nop_stall", 64'(stall_o), 0);
      chk("nop_done", 64'(done_o), 0);
    end
    valid_i = 1'b0; MemWE_i = 1'b1;
    @(negedge CLK);
    chk("novalid_stall", 64'(stall_o), 0);
    chk("novalid_done", 64'(done_o), 0);
    @(posedge CLK);
    #1;
    MemWE_i = 1'b0;

    StoreData_S_i = 'h33;
    wq.push_back({32'd9, 32'h33});
    run_op("st_win", 1, 1, 0, 9, 1);
    fin("st_win");
    chk("st_win_lds", 64'(LoadData_S_o), 14);
`ifdef VLSU_BOUNDS_CHECK_EN
    run_op("oob_v", 1, 0, 1, 240, 1);
    chk("oob_v_err", 64'(last_err), 1);
    fin("oob_v");
    push_vec(236, V);
    run_op("edge_v", 1, 0, 1, 236, V);
    chk("edge_v_err", 64'(last_err), 0);
    fin("edge_v");
    run_op("oob_ld", 0, 1, 0, 256, 1);
    chk("oob_ld_err", 64'(last_err), 1);
    chk("oob_ld_lds", 64'(LoadData_S_o), 14);
    fin("oob_ld");
    wq.push_back({32'd255, 32'h33});
    run_op("edge_s", 1, 0, 0, 255, 1);
    chk("edge_s_err", 64'(last_err), 0);
    fin("edge_s");
`else
    push_vec(32'hFFFF_FFF8, V);
    run_op("st_wrap", 1, 0, 1, 32'hFFFF_FFF8, V);
    fin("st_wrap");
`endif

    for (int i = 0; i < V; i++) StoreData_V_i[i] = N'(32'h100 + i);
    push_vec(100, 5);
    valid_i = 1'b1; MemWE_i = 1'b1; WBSelect_i = 1'b0; OpSource_i = 1'b1; Addr_i = 100;
    repeat (5) begin
      @(negedge CLK);
      chk("rstmid_stall", 64'(stall_o), 1);
    end
    #1;
    RST = 1'b0;
    #1;
    chk("rstmid_we", 64'(mem_we_o), 0);
    chk("rstmid_addr", 64'(mem_addr_o), 0);
    chk("rstmid_wdata", 64'(mem_wdata_o), 0);
    chk("rstmid_stall0", 64'(stall_o), 0);
    chk("rstmid_done", 64'(done_o), 0);
    chk("rstmid_lds", 64'(LoadData_S_o), 0);
    chk("rstmid_ldv", 64'(|LoadData_V_o), 0);
    @(posedge CLK);
    #1;
    valid_i = 1'b0; MemWE_i = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    StoreData_S_i = 'hDEAD;
    wq.push_back({32'd42, 32'hDEAD});
    run_op("st_after_rst", 1, 0, 0, 42, 1);
    fin("st_after_rst");
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_vector_lsu.md
# mem_vector_lsu

MEM-stage load/store unit that consumes the fields held by the EX/MEM pipeline register and performs scalar or vector memory accesses over a single-word data-memory port. Vector accesses are serialised one element per cycle. While an access is in progress, the unit drives `stall_o` so that upstream pipeline registers hold their contents through their `enable_i`. Load results are delivered in registers ready for the MEM/WB register.

## Interface
Parameters:
- `N`, 32, data and address word width
- `V`, 20, vector lanes
- `MEM_DEPTH`, 256, data-memory depth in words; used only with the bounds check

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  EX/MEM register holds a valid instruction
- `MemWE_i`  in  1  store
- `WBSelect_i`  in  1  load (memory data to writeback)
- `OpSource_i`  in  1  0 = scalar, 1 = vector
- `Addr_i`  in  N  base word address (ALU scalar result)
- `StoreData_S_i`  in  N  scalar store data
- `StoreData_V_i`  in  V×N  vector store data, element i at `[i]`
- `mem_addr_o`  out  N  memory word address
- `mem_we_o`  out  1  memory write strobe
- `mem_wdata_o`  out  N  memory write data
- `mem_rdata_i`  in  N  memory read data, valid one cycle after its address is presented
- `stall_o`  out  1  hold upstream pipeline (drives upstream `enable_i` low)
- `done_o`  out  1  one-cycle pulse marking the final cycle of a memory operation
- `LoadData_S_o`  out  N  scalar load result
- `LoadData_V_o`  out  V×N  vector load result
- `addr_err_o`  out  1  bounds violation; only present with the bounds check

## Operation
- **Decode in IDLE:**
  - `valid_i & MemWE_i` is a store.
  - Otherwise `valid_i & WBSelect_i` is a load.
  - Any other combination is a no-op: no stall, `done_o` = 0.
  - If `MemWE_i` and `WBSelect_i` are both set, the store wins.
- **States:** IDLE, STORE, LOAD, DONE. A counter `idx` (width ceil(log2(V+1))) tracks elements.
- **Scalar store:**
  - Completes in IDLE in a single cycle.
  - `mem_addr_o` = `Addr_i`, `mem_wdata_o` = `StoreData_S_i`, `mem_we_o` = 1, `done_o` = 1, `stall_o` = 0.
- **Vector store:**
  - Element 0 is written in IDLE, then the FSM moves to STORE with `idx` = 1.
  - Element i is written in cycle i with `mem_addr_o` = `Addr_i` + i and `mem_wdata_o` = `StoreData_V_i[i]`.
  - `stall_o` = 1 in cycles 0..V-2. In cycle V-1, `stall_o` = 0 and `done_o` = 1, then the FSM returns to IDLE.
- **Load:**
  - Address of element i is issued in cycle i.
  - `mem_rdata_i` is registered into element i at the end of cycle i+1.
  - Scalar: one element, written to `LoadData_S_o`. Vector: V elements, written to `LoadData_V_o`.
  - After the last capture the FSM enters DONE.
- **DONE:**
  - `stall_o` = 0, `done_o` = 1. Load registers are stable, so MEM/WB captures them on this edge.
  - `valid_i` is ignored, because the EX/MEM register still holds the completed instruction.
  - The FSM returns to IDLE.
- **Load registers** hold their value until they are overwritten by the next load.
- **Address arithmetic:** `Addr_i` + i is computed modulo 2^N.
- **Inputs** are assumed stable for the whole operation, because `stall_o` freezes EX/MEM. The unit does not latch them.

## Timing
- **Reset values (`RST` low):**
  - State IDLE, `idx` = 0.
  - `stall_o`, `done_o`, `mem_we_o`, `addr_err_o` = 0.
  - `mem_addr_o` and `mem_wdata_o` = 0.
  - `LoadData_S_o` and `LoadData_V_o` = 0.
  - `mem_we_o` is gated by `RST`, so a reset asserted mid-write kills the strobe immediately.
- **Reset mid-operation:** the operation is abandoned and no further writes occur. After release the unit starts in IDLE and decodes whatever is then on its inputs.
- **Latencies:**
  - Scalar store: 1 cycle, 0 stall cycles.
  - Vector store: V cycles, V-1 stall cycles.
  - Scalar load: 3 cycles, 2 stall cycles.
  - Vector load: V+2 cycles, V+1 stall cycles.
- **Back-to-back operations:** a new operation can be accepted in the cycle immediately after the final cycle of a store or after DONE.

## Configuration
- `VLSU_BOUNDS_CHECK_EN` defined:
  - In IDLE, an operation whose last element address (`Addr_i` + `V` - 1 for vector, `Addr_i` for scalar) is ≥ `MEM_DEPTH` is suppressed.
  - No write is issued and no load registers change.
  - `addr_err_o` = 1 and `done_o` = 1 for that single cycle, with no stall.
- Undefined: `addr_err_o` is absent and addresses wrap modulo 2^N.

## Structure
- Shared package `vlsu_pkg`:
  - FSM state enum.
  - Op-kind enum (NOP, LD_S, LD_V, ST_S, ST_V).
  - Decode function from `MemWE_i`, `WBSelect_i`, `OpSource_i`.
- Sub-module `vlsu_addr_gen`: element counter `idx` with clear/advance/last flags, plus the `Addr_i` + `idx` adder.

## Test plan
- **Scalar store:** `Addr_i` = 5, `StoreData_S_i` = 0xA5, `valid_i` = 1, `MemWE_i` = 1 → one cycle with `mem_we_o` = 1, address 5, data 0xA5, `done_o` = 1, `stall_o` never high.
- **Vector store:** `Addr_i` = 16, `StoreData_V_i[i]` = i+1 → 20 consecutive writes to addresses 16..35 with data 1..20; `stall_o` high for 19 cycles; `done_o` in cycle 19.
- **Vector load:** memory model returns `addr`×2, `Addr_i` = 0 → `LoadData_V_o[i]` = 2i in DONE (cycle 21); `stall_o` high for exactly 21 cycles.
- **Scalar load then no-op:** `Addr_i` = 7 → `LoadData_S_o` = 14 in DONE (cycle 2); a following `valid_i` with no memory op produces no stall and `done_o` = 0.
- **Reset mid vector store:** `RST` low at element 4 → `mem_we_o` drops immediately and all outputs read 0; after release, a scalar store executes normally.
- **Bounds check** (`VLSU_BOUNDS_CHECK_EN`, `MEM_DEPTH` = 256): vector store with `Addr_i` = 240 → `addr_err_o` = 1 and `done_o` = 1 for one cycle, zero writes, no stall.
